// File: rtl/riscv_multicycle_controller.sv
// Multicycle RISC-V main controller: FETCH/DECODE/EXEC/MEM/WB sequencer with
// memory wait-state handshakes, a per-handshake timeout and a sticky trap state.
module riscv_multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALUOP_W     = 2,
  parameter bit EN_JUMPS    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  output logic               imem_req,
  input  logic               imem_ready,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               branch,
  output logic               retire,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [2:0]         state_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // A zero timeout still needs a legal (1-bit) counter even though it never counts.
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [2:0]       state, state_nxt;
  logic [1:0]       cause_r, cause_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             is_legal, in_wait, mem_rdy, timeout;

  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LW, OP_SW, OP_BEQ: is_legal = 1'b1;
      OP_JAL, OP_JALR:                                    is_legal = EN_JUMPS;
      default:                                            is_legal = 1'b0;
    endcase
    in_wait = (state == S_FETCH) || (state == S_MEM);
    mem_rdy = (state == S_FETCH) ? imem_ready : dmem_ready;
    // Ready in the compare cycle wins over the timeout.
    timeout = (MEM_TIMEOUT > 0) && in_wait && !mem_rdy &&
              (wait_cnt == CNT_W'(MEM_TIMEOUT));
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = '0;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    state_nxt  = state;
    cause_nxt  = cause_r;
    case (state)
      S_FETCH: begin
        imem_req  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        if (imem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (timeout) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b10;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b01;
        end
      end
      S_EXEC: begin
        state_nxt = S_WB;
        case (opcode)
          OP_R: alu_op = ALUOP_W'(2'b10);
          OP_I: begin
            alu_src_b = 2'b01;
            alu_op    = ALUOP_W'(2'b10);
          end
          OP_LUI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = ALUOP_W'(2'b11);
          end
          OP_AUIPC: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 2'b01;
            state_nxt = S_MEM;
          end
          OP_BEQ: begin
            alu_op    = ALUOP_W'(2'b01);
            branch    = 1'b1;
            pc_src    = 2'b01;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
          OP_JAL, OP_JALR: begin
            alu_src_a  = (opcode == OP_JAL) ? 2'b01 : 2'b00;
            alu_src_b  = 2'b01;
            pc_write   = EN_JUMPS;
            pc_src     = 2'b10;
            reg_write  = EN_JUMPS;
            mem_to_reg = 2'b10;
            retire     = EN_JUMPS;
            state_nxt  = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_SW);
        if (dmem_ready) begin
          if (opcode == OP_SW) begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (timeout) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'b10;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LW) ? 2'b01 : 2'b00;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
  end

  // State, trap cause and wait counter; reset overrides any wait in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      cause_r  <= 2'b00;
      wait_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cause_r <= cause_nxt;
      if ((MEM_TIMEOUT > 0) && in_wait && !mem_rdy && (state_nxt == state))
        wait_cnt <= wait_cnt + CNT_W'(1);
      else
        wait_cnt <= '0;
    end
  end

  assign trap       = (state == S_TRAP);
  assign trap_cause = cause_r;
  assign state_o    = state;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Bench for riscv_multicycle_controller: per-instruction cycle plans built from the
// opcode/wait-state rules, compared against the DUT every cycle, plus pinned literals.
module tb_riscv_multicycle_controller;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic       imem_req, dmem_req, dmem_we, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg, trap_cause;
  logic       reg_write, branch, retire, trap;
  logic [2:0] state_o;

  riscv_multicycle_controller #(.MEM_TIMEOUT(TO), .ALUOP_W(2), .EN_JUMPS(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch(branch),
    .retire(retire), .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0] pc_src, a, b, op, m2r;
    logic       reg_write, branch, retire, trap;
    logic [1:0] cause;
    logic [2:0] st;
  } vec_t;

  vec_t exp_q[$];
  logic ir_q[$];
  logic dr_q[$];
  int   total = 0;
  int   bad = 0;
  int   last_lat;
  int   st_log[$];

  localparam logic [6:0] OPS [9] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                      7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                                      7'b1100111};

  // Class index = position in OPS, 9 = illegal.
  function automatic int cls(input logic [6:0] o);
    for (int i = 0; i < 9; i++) if (OPS[i] == o) return i;
    return 9;
  endfunction

  function automatic vec_t v_fetch(input logic rdy);
    vec_t v = '0;
    v.imem_req = 1'b1; v.a = 2'b01; v.b = 2'b10;
    v.ir_write = rdy;  v.pc_write = rdy;
    return v;
  endfunction

  task automatic push(input vec_t v, input logic ir, input logic dr);
    exp_q.push_back(v); ir_q.push_back(ir); dr_q.push_back(dr);
  endtask

  task automatic push_trap(input logic [1:0] c);
    vec_t v = '0;
    v.st = 3'd5; v.trap = 1'b1; v.cause = c;
    for (int k = 0; k < 3; k++) push(v, 1'b0, 1'b0);
  endtask

  task automatic plan(input logic [6:0] opc, input int iw, input int dw, output bit trapped);
    int   c;
    vec_t v;
    c = cls(opc);
    trapped = 1'b0;
    if (iw > TO) begin
      for (int k = 0; k <= TO; k++) push(v_fetch(1'b0), 1'b0, 1'b0);
      push_trap(2'b10); trapped = 1'b1; return;
    end
    for (int k = 0; k < iw; k++) push(v_fetch(1'b0), 1'b0, 1'b0);
    push(v_fetch(1'b1), 1'b1, 1'b0);
    v = '0; v.st = 3'd1; push(v, 1'b0, 1'b0);
    if (c == 9) begin push_trap(2'b01); trapped = 1'b1; return; end
    v = '0; v.st = 3'd2;
    case (c)
      0: v.op = 2'b10;
      1: begin v.b = 2'b01; v.op = 2'b10; end
      2: begin v.a = 2'b10; v.b = 2'b01; v.op = 2'b11; end
      3: begin v.a = 2'b01; v.b = 2'b01; end
      4, 5: v.b = 2'b01;
      6: begin v.op = 2'b01; v.branch = 1'b1; v.pc_src = 2'b01; v.retire = 1'b1; end
      default: begin
        v.a = (c == 7) ? 2'b01 : 2'b00; v.b = 2'b01; v.pc_write = 1'b1; v.pc_src = 2'b10;
        v.reg_write = 1'b1; v.m2r = 2'b10; v.retire = 1'b1;
      end
    endcase
    push(v, 1'b0, 1'b0);
    if (c >= 6) return;
    if (c == 4 || c == 5) begin
      v = '0; v.st = 3'd3; v.dmem_req = 1'b1; v.dmem_we = (c == 5);
      if (dw > TO) begin
        for (int k = 0; k <= TO; k++) push(v, 1'b0, 1'b0);
        push_trap(2'b10); trapped = 1'b1; return;
      end
      for (int k = 0; k < dw; k++) push(v, 1'b0, 1'b0);
      v.retire = (c == 5);
      push(v, 1'b0, 1'b1);
      if (c == 5) return;
    end
    v = '0; v.st = 3'd4; v.reg_write = 1'b1; v.retire = 1'b1;
    v.m2r = (c == 4) ? 2'b01 : 2'b00;
    push(v, 1'b0, 1'b0);
  endtask

  task automatic compare(input vec_t e, input int cyc);
    vec_t act;
    act.imem_req = imem_req; act.dmem_req = dmem_req; act.dmem_we = dmem_we;
    act.ir_write = ir_write; act.pc_write = pc_write; act.pc_src = pc_src;
    act.a = alu_src_a; act.b = alu_src_b; act.op = alu_op; act.m2r = mem_to_reg;
    act.reg_write = reg_write; act.branch = branch; act.retire = retire;
    act.trap = trap; act.cause = trap_cause; act.st = state_o;
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL outputs opc=%b cycle=%0d: got %h expected %h", opcode, cyc, act, e);
    end
  endtask

  task automatic run_plan();
    int   cyc = 0;
    vec_t e;
    last_lat = -1;
    st_log.delete();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      imem_ready = ir_q.pop_front();
      dmem_ready = dr_q.pop_front();
      #1;
      compare(e, cyc);
      st_log.push_back(int'(state_o));
      if (last_lat < 0 && retire === 1'b1) last_lat = cyc + 1;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_one(input logic [6:0] opc, input int iw, input int dw);
    bit tr;
    opcode = opc;
    plan(opc, iw, dw, tr);
    run_plan();
    if (tr) do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         tr;
    logic [6:0] opc;
    int         r, iw, dw;
    reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = 7'b0110011;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_state", int'(state_o), 0);
    chk("reset_imem_req", int'(imem_req), 1);
    chk("reset_trap", int'({trap, trap_cause}), 0);

    run_one(7'b0110011, 0, 0);
    chk("r_latency", last_lat, 4);
    chk("r_states", (st_log.size() == 4) ?
        st_log[0] * 1000 + st_log[1] * 100 + st_log[2] * 10 + st_log[3] : -1, 124);
    run_one(7'b0000011, 0, 3);
    chk("lw_latency", last_lat, 8);
    run_one(7'b0100011, 0, 2);
    chk("sw_latency", last_lat, 6);
    run_one(7'b1100011, 0, 0);
    chk("beq_latency", last_lat, 3);
    run_one(7'b1101111, 0, 0);
    chk("jal_latency", last_lat, 3);

    opcode = 7'b1111111;
    plan(opcode, 0, 0, tr); run_plan();
    chk("illegal_trap", int'({trap, trap_cause}), 5);
    do_reset();
    opcode = 7'b0110011;
    plan(opcode, 17, 0, tr); run_plan();
    chk("fetch_timeout_trap", int'({trap, trap_cause}), 6);
    do_reset();
    run_one(7'b0110011, 16, 0);
    chk("ready_wins_latency", last_lat, 20);
    opcode = 7'b0000011;
    plan(opcode, 0, 17, tr); run_plan();
    chk("mem_timeout_trap", int'({trap, trap_cause}), 6);
    do_reset();

    // Reset while a load is waiting in MEM.
    opcode = 7'b0000011; imem_ready = 1'b1; dmem_ready = 1'b0;
    @(negedge clk); imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_mem_state", int'({state_o, dmem_req}), 7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("after_mem_reset", int'({state_o, dmem_req, imem_req, trap}), 2);
    @(negedge clk);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      opc = (r < 18) ? OPS[r % 9] : 7'($urandom_range(0, 127));
      iw = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 17) : $urandom_range(0, 3);
      dw = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 17) : $urandom_range(0, 3);
      run_one(opc, iw, dw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
